// File: rtl/regfile_pkg.sv
// Shared constants and scrub sequencer state encoding for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned NUM_RD_DEF   = 2;
  localparam int unsigned NUM_WR_DEF   = 2;
  localparam int unsigned ZERO_REG_DEF = 1;
  localparam int unsigned BYPASS_DEF   = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } scrubState_e;

endpackage

// File: rtl/rf_rd_port.sv
// One registered read port: array select, same-cycle write forwarding, entry-0 masking.
module rf_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_WR   = NUM_WR_DEF,
  parameter int unsigned ZERO_REG = ZERO_REG_DEF,
  parameter int unsigned BYPASS   = BYPASS_DEF
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     rdEn,
  input  logic [ADDR_W-1:0]        rdAddr,
  input  logic [DATA_W-1:0]        mem [2**ADDR_W],
  input  logic [NUM_WR-1:0]        wrAcc,
  input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
  input  logic [NUM_WR*DATA_W-1:0] wrData,
  output logic [DATA_W-1:0]        rdData,
  output logic                     rdValid
);

  logic [DATA_W-1:0] readVal_c;

  // Later write ports overwrite earlier matches, so the highest port wins the forward.
  always_comb begin
    readVal_c = mem[rdAddr];
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (BYPASS != 0 && wrAcc[p] && wrAddr[p*ADDR_W +: ADDR_W] == rdAddr)
        readVal_c = wrData[p*DATA_W +: DATA_W];
    end
    if (ZERO_REG != 0 && rdAddr == '0)
      readVal_c = '0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= rdEn;
      if (rdEn)
        rdData <= readVal_c;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional zero register, write forwarding and a whole-array scrub.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned NUM_WR   = NUM_WR_DEF,
  parameter int unsigned ZERO_REG = ZERO_REG_DEF,
  parameter int unsigned BYPASS   = BYPASS_DEF
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [NUM_WR-1:0]        wr_ack,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     scrub_req,
  output logic                     busy,
  output logic                     scrub_done
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  scrubState_e       state, nextState;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_WR-1:0] wrAcc;

  // Writes are refused while the scrub owns the array.
  assign wrAcc  = wr_en & ~{NUM_WR{busy}};
  assign wr_ack = wrAcc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= (state == SCRUB) ? cnt + ADDR_W'(1) : '0;
    end
  end

  always_comb begin
    nextState  = state;
    busy       = 1'b0;
    scrub_done = 1'b0;
    case (state)
      IDLE: begin
        if (scrub_req)
          nextState = SCRUB;
      end
      SCRUB: begin
        busy = 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          scrub_done = 1'b1;
          nextState  = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Ascending port loop lets port 1 win an address collision.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= '0;
    end else if (busy) begin
      mem[cnt] <= '0;
    end else begin
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (wrAcc[p] && !(ZERO_REG != 0 && wr_addr[p*ADDR_W +: ADDR_W] == '0))
          mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar q = 0; q < int'(NUM_RD); q++) begin : gRd
    rf_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) uRdPort (
      .clk    (clk),
      .clr    (clr),
      .rdEn   (rd_en[q]),
      .rdAddr (rd_addr[q*ADDR_W +: ADDR_W]),
      .mem    (mem),
      .wrAcc  (wrAcc),
      .wrAddr (wr_addr),
      .wrData (wr_data),
      .rdData (rd_data[q*DATA_W +: DATA_W]),
      .rdValid(rd_valid[q])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp at default parameters (32x32, 2R/2W, zero reg, bypass).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  wr_en, wr_ack, rd_en, rd_valid;
  logic [9:0]  wr_addr, rd_addr;
  logic [63:0] wr_data, rd_data;
  logic        scrub_req, busy, scrub_done;

  regfile_mp dut (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .scrub_req (scrub_req),
    .busy      (busy),
    .scrub_done(scrub_done)
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] mMem [32];
  logic        mBusy;
  int          mCnt;
  logic [31:0] expQ0[$], expQ1[$];
  logic [31:0] lastData [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mMem[i] = '0;
    mBusy = 1'b0;
    mCnt  = 0;
    expQ0.delete();
    expQ1.delete();
    lastData[0] = '0;
    lastData[1] = '0;
  endtask

  task automatic idle();
    wr_en = '0; rd_en = '0; scrub_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  function automatic logic [31:0] modelRead(input int q);
    logic [4:0]  a;
    logic [31:0] v;
    a = rd_addr[q*5 +: 5];
    v = mMem[a];
    if (!mBusy)
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*5 +: 5] == a) v = wr_data[p*32 +: 32];
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  // Inputs are set up after a negedge; check comb outputs, push expectations, clock, then score.
  task automatic step();
    logic [1:0]  pend;
    logic [31:0] e;
    #1;
    chk("busy", 32'(busy), 32'(mBusy));
    chk("scrub_done", 32'(scrub_done), 32'(mBusy && mCnt == 31));
    chk("wr_ack", 32'(wr_ack), 32'(wr_en & ~{2{mBusy}}));
    pend = rd_en;
    if (rd_en[0]) expQ0.push_back(modelRead(0));
    if (rd_en[1]) expQ1.push_back(modelRead(1));
    if (mBusy) begin
      mMem[mCnt] = '0;
      if (mCnt == 31) begin mBusy = 1'b0; mCnt = 0; end
      else mCnt++;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*5 +: 5] != 5'd0) mMem[wr_addr[p*5 +: 5]] = wr_data[p*32 +: 32];
      if (scrub_req) begin mBusy = 1'b1; mCnt = 0; end
    end
    @(posedge clk);
    #1;
    chk("rd_valid0", 32'(rd_valid[0]), 32'(pend[0]));
    chk("rd_valid1", 32'(rd_valid[1]), 32'(pend[1]));
    if (pend[0] && expQ0.size() > 0) begin e = expQ0.pop_front(); lastData[0] = e; end
    if (pend[1] && expQ1.size() > 0) begin e = expQ1.pop_front(); lastData[1] = e; end
    chk("rd_data0", rd_data[31:0], lastData[0]);
    chk("rd_data1", rd_data[63:32], lastData[1]);
    @(negedge clk);
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int q, input logic [4:0] a);
    rd_en[q] = 1'b1;
    rd_addr[q*5 +: 5] = a;
  endtask

  task automatic fillAll();
    for (int i = 0; i < 16; i++) begin
      idle();
      wr(0, 5'(i), $urandom | 32'h1);
      wr(1, 5'(i + 16), $urandom | 32'h1);
      step();
    end
  endtask

  task automatic readAll();
    for (int i = 0; i < 32; i += 2) begin
      idle(); rd(0, 5'(i)); rd(1, 5'(i + 1)); step();
    end
  endtask

  int busyCnt, doneAt;

  initial begin
    idle();
    modelReset();
    clr = 1'b1;
    #12;
    chk("rst_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(scrub_done), 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // Basic write then read on the other port
    idle(); wr(0, 5'd5, 32'hDEADBEEF); step();
    idle(); rd(1, 5'd5); step();
    chk("deadbeef", rd_data[63:32], 32'hDEADBEEF);

    // Write collision with same-cycle read of the target
    idle(); wr(0, 5'd7, 32'h1111); wr(1, 5'd7, 32'h2222); rd(0, 5'd7); step();
    chk("bypass_collide", rd_data[31:0], 32'h2222);
    idle(); rd(1, 5'd7); step();
    chk("collide_later", rd_data[63:32], 32'h2222);

    // Zero register with forwarding attempt, then a plain read
    idle(); wr(0, 5'd0, 32'hFFFFFFFF); rd(1, 5'd0); step();
    idle(); rd(0, 5'd0); step();
    chk("zero_reg", rd_data[31:0], 32'h0);

    // rd_en low holds data
    idle(); step(); step();

    // Full scrub with writes and reads in flight
    fillAll();
    readAll();
    idle(); scrub_req = 1'b1; step();
    busyCnt = 0; doneAt = 0;
    for (int c = 1; c <= 40 && (busy || c == 1); c++) begin
      idle();
      wr(0, 5'd3, 32'hA5A5A5A5);
      rd(0, 5'($urandom_range(31)));
      rd(1, 5'($urandom_range(31)));
      if (c == 5) scrub_req = 1'b1;
      #1;
      if (busy) busyCnt++;
      if (scrub_done) doneAt = c;
      step();
    end
    chk("scrub_len", busyCnt, 32);
    chk("scrub_done_at", doneAt, 32);
    chk("busy_after", 32'(busy), 32'h0);
    readAll();

    // Reset in the middle of a scrub
    fillAll();
    idle(); scrub_req = 1'b1; step();
    for (int c = 1; c < 10; c++) begin idle(); step(); end
    #2;
    clr = 1'b1;
    #1;
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_done", 32'(scrub_done), 32'h0);
    chk("clr_valid", 32'(rd_valid), 32'h0);
    chk("clr_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    modelReset();
    @(negedge clk);
    clr = 1'b0;
    readAll();
    idle(); wr(1, 5'd9, 32'h12345678); step();
    idle(); rd(0, 5'd9); step();
    chk("post_clr_wr", rd_data[31:0], 32'h12345678);

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      idle();
      wr_en   = 2'($urandom);
      rd_en   = 2'($urandom);
      wr_addr = 10'($urandom);
      rd_addr = 10'($urandom);
      if ($urandom_range(3) == 0) rd_addr[4:0] = wr_addr[4:0];
      if ($urandom_range(3) == 0) wr_addr[9:5] = wr_addr[4:0];
      wr_data   = {$urandom, $urandom};
      scrub_req = ($urandom_range(99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
